// File: rtl/sg90_servo_ctrl.sv
// sg90_servo_ctrl: 50 Hz SG90 servo PWM. Keys adjust a target position, and the applied
// position follows it once per frame. Optional macro SG90_SLEW_EN limits the per-frame
// change to SLEW. Without the macro, the position jumps to the target at each frame boundary.
module sg90_servo_ctrl #(
    parameter int CLK_FREQ = 50_000_000,
    parameter int FRAME_US = 20000,
    parameter int MIN_US   = 500,
    parameter int POS_MAX  = 200,
    parameter int HOME_POS = 100,
    parameter int STEP     = 10,
    parameter int SLEW     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       key_inc,
    input  logic       key_dec,
    input  logic       key_home,
    output logic       pwm_out,
    output logic [7:0] pos,
    output logic       busy,
    output logic       frame_start
);
    localparam int DIV = CLK_FREQ / 1_000_000;
    localparam int PW  = DIV > 1 ? $clog2(DIV) : 1;
    localparam int UW  = $clog2(FRAME_US);

    typedef enum logic {IDLE, RUN} state_t;

    state_t        state;
    logic [PW-1:0] presc;
    logic [UW-1:0] us;
    logic [8:0]    target, pos_r, target_nxt, pos_nxt, t_up, t_dn;
    logic [11:0]   width;
    logic          tick, end_ev;

    assign tick   = presc == PW'(DIV - 1);
    assign end_ev = tick && us == UW'(FRAME_US - 1);
    assign pos    = pos_r[7:0];

    assign t_up = (int'(target) + STEP > POS_MAX) ? 9'(POS_MAX) : target + 9'(STEP);
    assign t_dn = (int'(target) < STEP) ? '0 : target - 9'(STEP);
    assign target_nxt = key_home ? 9'(HOME_POS) :
                        (key_inc && !key_dec) ? t_up :
                        (key_dec && !key_inc) ? t_dn : target;

`ifdef SG90_SLEW_EN
    assign pos_nxt = (target > pos_r) ?
                     ((target - pos_r > 9'(SLEW)) ? pos_r + 9'(SLEW) : target) :
                     ((pos_r - target > 9'(SLEW)) ? pos_r - 9'(SLEW) : target);
`else
    assign pos_nxt = target;
`endif

    // Prescaler produces a 1 us tick and the us counter spans one frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc <= '0;
            us    <= '0;
        end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick)
                us <= end_ev ? '0 : us + UW'(1);
        end
    end

    // Target follows the keys every cycle. Position moves only at the frame end, using the pre-key target.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            target <= 9'(HOME_POS);
            pos_r  <= 9'(HOME_POS);
            busy   <= 1'b0;
        end else begin
            target <= target_nxt;
            if (end_ev)
                pos_r <= pos_nxt;
            busy <= pos_r != target;
        end
    end

    // Frame FSM: on frame_start, latch width and enable state. The pulse is held off for that one cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            width       <= 12'(MIN_US + HOME_POS * 10);
            frame_start <= 1'b0;
            pwm_out     <= 1'b0;
        end else begin
            frame_start <= end_ev;
            if (frame_start) begin
                width <= 12'(MIN_US + int'(pos_r) * 10);
                state <= enable ? RUN : IDLE;
            end
            pwm_out <= state == RUN && 16'(us) < 16'(width) && !frame_start;
        end
    end
endmodule
